viterbi_traceback: RTL and testbench

Backpointer store and traceback stage of the Viterbi POS tagger, directly downstream of the max/argmax stage. For every (word, current POS) pair it records the winning predecessor index (`max_index`) produced by the max stage. After the final word it starts from the last-word argmax (`last_POS`) and walks the backpointers in reverse. It emits one POS tag per word through a valid/ready handshake, last word first.

---
 rtl/viterbi_pkg.sv | 15 +
 rtl/viterbi_bp_mem.sv | 39 +++
 rtl/viterbi_traceback.sv | 121 ++++++++++++
 tb/tb_viterbi_traceback.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - constants and FSM state type shared by the Viterbi tagger stages
package viterbi_pkg;

    localparam int word_num     = 16;  // maximum sentence length
    localparam int word_num_bit = 4;   // width of a word index
    localparam int POS_num      = 11;  // number of POS states
    localparam int POS_num_bit  = 4;   // width of a POS index

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } tb_state_t;

endpackage

// File: rtl/viterbi_bp_mem.sv
// rtl/viterbi_bp_mem.sv - backpointer array with range-gated write and combinational read
//   clk                          : clock
//   wr_allow                     : top-level permission to write (FSM idle)
//   bp_we/bp_word/bp_state/bp_index : write request
//   rd_word/rd_state             : read address
//   rd_index                     : stored predecessor, zero for an out-of-range state
module viterbi_bp_mem
    import viterbi_pkg::*;
(
    input  logic                    clk,
    input  logic                    wr_allow,
    input  logic                    bp_we,
    input  logic [word_num_bit-1:0] bp_word,
    input  logic [POS_num_bit-1:0]  bp_state,
    input  logic [POS_num_bit-1:0]  bp_index,
    input  logic [word_num_bit-1:0] rd_word,
    input  logic [POS_num_bit-1:0]  rd_state,
    output logic [POS_num_bit-1:0]  rd_index
);

    // Deliberately not reset: the array is rewritten for every sentence.
    logic [POS_num_bit-1:0] mem [word_num][POS_num];
    logic                   wr_ok;

    // Indices are widened before comparing so the bound checks stay
    // meaningful even when an index width exactly covers its range.
    assign wr_ok = bp_we && wr_allow
                && (32'(bp_word)  < word_num)
                && (32'(bp_state) < POS_num);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bp_word][bp_state] <= bp_index;
        end
    end

    assign rd_index = (32'(rd_state) < POS_num) ? mem[rd_word][rd_state] : '0;

endmodule

// File: rtl/viterbi_traceback.sv
// rtl/viterbi_traceback.sv - Viterbi backpointer store and reverse traceback with valid/ready output
//   clk, reset                     : clock, synchronous active-high reset
//   bp_we/bp_word/bp_state/bp_index : backpointer write (accepted only while idle)
//   start/num_words/last_POS        : traceback request
//   busy                            : traceback in progress
//   out_valid/out_ready/out_word/out_pos : tag stream, last word first
//   done                            : one-cycle end pulse (normal, abort or rejected start)
//   err                             : sticky error flag
module viterbi_traceback
    import viterbi_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bp_we,
    input  logic [word_num_bit-1:0] bp_word,
    input  logic [POS_num_bit-1:0]  bp_state,
    input  logic [POS_num_bit-1:0]  bp_index,
    input  logic                    start,
    input  logic [word_num_bit:0]   num_words,
    input  logic [POS_num_bit-1:0]  last_POS,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [word_num_bit-1:0] out_word,
    output logic [POS_num_bit-1:0]  out_pos,
    output logic                    done,
    output logic                    err
);

    tb_state_t               state;
    logic [word_num_bit-1:0] t;
    logic [POS_num_bit-1:0]  cur;
    logic [POS_num_bit-1:0]  nxt;
    logic                    len_ok;
    logic                    last_ok;
    logic                    nxt_ok;

    viterbi_bp_mem u_mem (
        .clk      (clk),
        .wr_allow (state == IDLE),
        .bp_we    (bp_we),
        .bp_word  (bp_word),
        .bp_state (bp_state),
        .bp_index (bp_index),
        .rd_word  (t),
        .rd_state (cur),
        .rd_index (nxt)
    );

    assign len_ok  = (num_words != '0) && (32'(num_words) <= word_num);
    assign last_ok = 32'(last_POS) < POS_num;
    assign nxt_ok  = 32'(nxt) < POS_num;

    // The tag on the bus is always the live t/cur pair.
    assign out_word = t;
    assign out_pos  = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            t         <= '0;
            cur       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            // num_words == word_num wraps the low bits to 0, so -1 still lands on word_num-1.
                            t    <= num_words[word_num_bit-1:0] - 1'b1;
                            cur  <= last_POS;
                            busy <= 1'b1;
                            if (last_ok) begin
                                err       <= 1'b0;
                                out_valid <= 1'b1;
                                state     <= EMIT;
                            end else begin
                                // Nothing valid to emit; close out through FIN with the error flagged.
                                err   <= 1'b1;
                                done  <= 1'b1;
                                state <= FIN;
                            end
                        end else begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        if (t == '0) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= FIN;
                        end else if (nxt_ok) begin
                            t   <= t - 1'b1;
                            cur <= nxt;
                        end else begin
                            // Corrupt backpointer: drop the remaining tags.
                            t         <= t - 1'b1;
                            err       <= 1'b1;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= FIN;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// tb/tb_viterbi_traceback.sv - scoreboard bench for viterbi_traceback
module tb_viterbi_traceback;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bp_we = 1'b0;
    logic [3:0] bp_word = '0;
    logic [3:0] bp_state = '0;
    logic [3:0] bp_index = '0;
    logic       start = 1'b0;
    logic [4:0] num_words = '0;
    logic [3:0] last_POS = '0;
    logic       out_ready = 1'b1;
    logic       busy, out_valid, done, err;
    logic [3:0] out_word, out_pos;

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int base = 0;

    logic [7:0] tag_q[$];
    bit         err_q[$];
    logic [7:0] mon_e;
    bit         mon_b;

    viterbi_traceback dut (
        .clk       (clk),
        .reset     (reset),
        .bp_we     (bp_we),
        .bp_word   (bp_word),
        .bp_state  (bp_state),
        .bp_index  (bp_index),
        .start     (start),
        .num_words (num_words),
        .last_POS  (last_POS),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_pos   (out_pos),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted tag and every done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (tag_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tag: got (%0d,%0d) expected none", out_word, out_pos);
                end else begin
                    mon_e = tag_q.pop_front();
                    check("tag_word", 32'(out_word), 32'(mon_e[7:4]));
                    check("tag_pos", 32'(out_pos), 32'(mon_e[3:0]));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc_n;
                check("done_no_valid", 32'(out_valid), 0);
                if (err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    mon_b = err_q.pop_front();
                    check("done_err", 32'(err), 32'(mon_b));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bp(input logic [3:0] w, input logic [3:0] s, input logic [3:0] i);
        bp_we = 1'b1; bp_word = w; bp_state = s; bp_index = i;
        cyc();
        bp_we = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] n, input logic [3:0] lp);
        start = 1'b1; num_words = n; last_POS = lp;
        cyc();
        start = 1'b0;
        start_cyc = cyc_n;
    endtask

    task automatic wait_done(input int b);
        int n = 0;
        while (done_cnt == b && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == b) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
        cyc();
    endtask

    task automatic push_three(input logic [3:0] mid_pos, input logic [3:0] last_pos);
        tag_q.push_back(8'h25);
        tag_q.push_back({4'd1, mid_pos});
        tag_q.push_back({4'd0, last_pos});
    endtask

    initial begin
        // Reset values
        repeat (3) cyc();
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_word", 32'(out_word), 0);
        check("rst_pos", 32'(out_pos), 0);
        cyc();
        reset = 1'b0;
        cyc();

        // 3-word trace, out_ready held high
        write_bp(4'd2, 4'd5, 4'd3);
        write_bp(4'd1, 4'd3, 4'd7);
        write_bp(4'd1, 4'd6, 4'd0);
        push_three(4'd3, 4'd7);
        err_q.push_back(1'b0);
        base = done_cnt;
        do_start(5'd3, 4'd5);
        check("start_busy", 32'(busy), 1);
        check("start_valid", 32'(out_valid), 1);
        wait_done(base);
        check("latency3", done_cyc - start_cyc, 3);
        check("idle_busy", 32'(busy), 0);

        // Backpressure on the second tag
        push_three(4'd3, 4'd7);
        err_q.push_back(1'b0);
        base = done_cnt;
        do_start(5'd3, 4'd5);
        cyc();
        out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_word", 32'(out_word), 1);
            check("bp_pos", 32'(out_pos), 3);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_done(base);
        check("bp_drained", tag_q.size(), 0);

        // Illegal lengths
        for (int k = 0; k < 2; k++) begin
            err_q.push_back(1'b1);
            base = done_cnt;
            do_start((k == 0) ? 5'd0 : 5'd17, 4'd0);
            @(negedge clk);
            check("ill_done", 32'(done), 1);
            check("ill_err", 32'(err), 1);
            check("ill_valid", 32'(out_valid), 0);
            check("ill_busy", 32'(busy), 0);
            wait_done(base);
        end

        // last_POS out of range: no tag, error
        err_q.push_back(1'b1);
        base = done_cnt;
        do_start(5'd1, 4'd11);
        wait_done(base);

        // Bad backpointer stops the trace after the first tag
        write_bp(4'd1, 4'd4, 4'd12);
        tag_q.push_back(8'h14);
        err_q.push_back(1'b1);
        base = done_cnt;
        do_start(5'd2, 4'd4);
        wait_done(base);
        check("err_sticky", 32'(err), 1);

        // Write gating: out-of-range state and writes while busy are dropped
        write_bp(4'd2, 4'd11, 4'd9);
        out_ready = 1'b0;
        push_three(4'd3, 4'd7);
        err_q.push_back(1'b0);
        base = done_cnt;
        do_start(5'd3, 4'd5);
        write_bp(4'd2, 4'd5, 4'd9);
        write_bp(4'd1, 4'd3, 4'd1);
        out_ready = 1'b1;
        wait_done(base);
        check("err_cleared", 32'(err), 0);

        // Write together with start: the new backpointer is used
        push_three(4'd6, 4'd0);
        err_q.push_back(1'b0);
        base = done_cnt;
        bp_we = 1'b1; bp_word = 4'd2; bp_state = 4'd5; bp_index = 4'd6;
        do_start(5'd3, 4'd5);
        bp_we = 1'b0;
        wait_done(base);

        // Reset in the middle of a 10-word trace
        for (int w = 9; w >= 1; w--) write_bp(4'(w), 4'(9 - w), 4'(10 - w));
        tag_q.push_back(8'h90);
        tag_q.push_back(8'h81);
        base = done_cnt;
        do_start(5'd10, 4'd0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_done", 32'(done), 0);
        reset = 1'b0;
        repeat (3) cyc();
        check("mid_rst_no_done", done_cnt, base);
        check("mid_rst_tags", tag_q.size(), 0);

        // Replay from the untouched memory
        for (int w = 9; w >= 0; w--) tag_q.push_back({4'(w), 4'(9 - w)});
        err_q.push_back(1'b0);
        base = done_cnt;
        do_start(5'd10, 4'd0);
        wait_done(base);
        check("latency10", done_cyc - start_cyc, 10);

        check("tags_left", tag_q.size(), 0);
        check("dones_left", err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
